// File: rtl/brick_store_ctrl.sv
// Brick storage controller: per-brick hit points, init sweep, one query per handshake.
// Optional multi-hit bricks are enabled with `define BRICK_HP_EN; otherwise each brick is a single live bit.
module brick_store_ctrl #(
  parameter int NUM_BRICKS = 60,
  parameter int ADDR_W     = 6,
  parameter int HP_W       = 2,
  parameter int INIT_HP    = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              reload,
  input  logic              query_valid,
  input  logic [ADDR_W-1:0] query_addr,
  input  logic              query_hit,
  output logic              query_ready,
  output logic              resp_valid,
  output logic              resp_alive,
  output logic [HP_W-1:0]   resp_hp,
  output logic              resp_destroyed,
  output logic [ADDR_W:0]   bricks_left,
  output logic              loading,
  output logic              all_cleared
);

`ifdef BRICK_HP_EN
  localparam int STORE_W = HP_W;
  localparam logic [STORE_W-1:0] INIT_VAL = STORE_W'(INIT_HP);
`else
  localparam int STORE_W = 1;
  // Any nonzero starting hit-point value collapses to a single live bit.
  localparam logic [STORE_W-1:0] INIT_VAL = 1'(INIT_HP != 0);
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BRICKS - 1);
  localparam logic [ADDR_W:0]   BRICK_CNT = (ADDR_W + 1)'(NUM_BRICKS);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_UPDATE,
    S_RESP
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   sweep_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                hit_q;
  logic [STORE_W-1:0]  hp_q;
  logic [ADDR_W:0]     left_q;
  logic                loading_q;
  logic                ready_q;
  logic                resp_valid_q;
  logic                resp_alive_q;
  logic [HP_W-1:0]     resp_hp_q;
  logic                resp_destroyed_q;

  logic [STORE_W-1:0]  mem_q [NUM_BRICKS];

  logic                in_range;
  logic                hp_live;
  logic                do_hit;
  logic [STORE_W-1:0]  hp_d;
  logic                kills;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [STORE_W-1:0]  mem_wdata;

  assign in_range = {1'b0, addr_q} < BRICK_CNT;
  assign hp_live  = hp_q != '0;
  assign do_hit   = hit_q && in_range && hp_live;
  assign hp_d     = do_hit ? hp_q - STORE_W'(1) : hp_q;
  assign kills    = do_hit && (hp_d == '0);

  // The sweep owns the write port during INIT; UPDATE writes only a real hit.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = hp_d;
    if (state_q == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_q;
      mem_wdata = INIT_VAL;
    end else if (state_q == S_UPDATE) begin
      mem_we    = do_hit;
    end
  end

  // NOTE: the brick array has no reset; the init sweep gives it defined contents before any read.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q          <= S_INIT;
      sweep_q          <= '0;
      addr_q           <= '0;
      hit_q            <= 1'b0;
      hp_q             <= '0;
      left_q           <= '0;
      loading_q        <= 1'b1;
      ready_q          <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_alive_q     <= 1'b0;
      resp_hp_q        <= '0;
      resp_destroyed_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        S_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == LAST_ADDR) begin
            sweep_q   <= '0;
            left_q    <= BRICK_CNT;
            loading_q <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (query_valid) begin
            addr_q  <= query_addr;
            hit_q   <= query_hit;
            ready_q <= 1'b0;
            state_q <= S_READ;
          end else if (reload) begin
            sweep_q   <= '0;
            loading_q <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= S_INIT;
          end
        end
        S_READ: begin
          hp_q    <= in_range ? mem_q[addr_q] : '0;
          state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          resp_valid_q     <= 1'b1;
          resp_alive_q     <= hp_live;
          resp_hp_q        <= HP_W'(hp_d);
          resp_destroyed_q <= kills;
          if (kills && (left_q != '0)) begin
            left_q <= left_q - 1'b1;
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (reload) begin
            sweep_q   <= '0;
            loading_q <= 1'b1;
            state_q   <= S_INIT;
          end else begin
            ready_q   <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign query_ready    = ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_alive     = resp_alive_q;
  assign resp_hp        = resp_hp_q;
  assign resp_destroyed = resp_destroyed_q;
  assign bricks_left    = left_q;
  assign loading        = loading_q;
  assign all_cleared    = (left_q == '0) && !loading_q;

endmodule

// File: tb/tb_brick_store_ctrl.sv
// Self-checking bench for brick_store_ctrl: vector table plus scoreboard of expected responses.
// Expectations follow the BRICK_HP_EN setting used for the build.
module tb_brick_store_ctrl;

  localparam int NB  = 60;
  localparam int AW  = 6;
  localparam int HW  = 2;
  localparam int IHP = 2;
`ifdef BRICK_HP_EN
  localparam int E   = IHP;
`else
  localparam int E   = 1;
`endif

  logic          clock;
  logic          resetn;
  logic          reload;
  logic          query_valid;
  logic [AW-1:0] query_addr;
  logic          query_hit;
  logic          query_ready;
  logic          resp_valid;
  logic          resp_alive;
  logic [HW-1:0] resp_hp;
  logic          resp_destroyed;
  logic [AW:0]   bricks_left;
  logic          loading;
  logic          all_cleared;

  brick_store_ctrl #(
    .NUM_BRICKS(NB),
    .ADDR_W    (AW),
    .HP_W      (HW),
    .INIT_HP   (IHP)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .reload        (reload),
    .query_valid   (query_valid),
    .query_addr    (query_addr),
    .query_hit     (query_hit),
    .query_ready   (query_ready),
    .resp_valid    (resp_valid),
    .resp_alive    (resp_alive),
    .resp_hp       (resp_hp),
    .resp_destroyed(resp_destroyed),
    .bricks_left   (bricks_left),
    .loading       (loading),
    .all_cleared   (all_cleared)
  );

  typedef struct packed {
    logic          alive;
    logic [HW-1:0] hp;
    logic          destroyed;
    logic [AW:0]   left;
  } resp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          hit;
    resp_t         exp;
  } vec_t;

  int    n_vec = 0;
  int    n_err = 0;
  resp_t sb_q[$];
  resp_t mon_exp;
  int    model_hp [NB];
  int    model_left;
  vec_t  tbl [8];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) model_hp[i] = E;
    model_left = NB;
  endfunction

  function automatic resp_t model_step(input int a, input logic h);
    resp_t r;
    int pre, post;
    r = '0;
    if (a < NB) begin
      pre  = model_hp[a];
      post = (h && pre > 0) ? pre - 1 : pre;
      r.alive     = pre > 0;
      r.hp        = HW'(post);
      r.destroyed = h && (pre == 1);
      if (r.destroyed && model_left > 0) model_left--;
      model_hp[a] = post;
    end
    r.left = (AW + 1)'(model_left);
    return r;
  endfunction

  // Every response strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: got resp_valid=1 required no response");
      end else begin
        mon_exp = sb_q.pop_front();
        check("resp_alive", 32'(resp_alive), 32'(mon_exp.alive));
        check("resp_hp", 32'(resp_hp), 32'(mon_exp.hp));
        check("resp_destroyed", 32'(resp_destroyed), 32'(mon_exp.destroyed));
        check("bricks_left_resp", 32'(bricks_left), 32'(mon_exp.left));
      end
    end
  end

  task automatic wait_ready(input string name);
    int cyc;
    cyc = 0;
    while (query_ready !== 1'b1 && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    check(name, 32'(cyc), 32'(NB));
    check({name, "_loading_low"}, 32'(loading), 32'd0);
  endtask

  // Called on a negedge in IDLE; rel keeps reload high from acceptance through RESP.
  task automatic send(input logic [AW-1:0] a, input logic h, input resp_t exp, input logic rel);
    int lat;
    query_valid = 1'b1;
    query_addr  = a;
    query_hit   = h;
    reload      = rel;
    sb_q.push_back(exp);
    @(negedge clock);
    query_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("resp_latency", 32'(lat), 32'd3);
    @(negedge clock);
    reload = 1'b0;
    check("resp_strobe_width", 32'(resp_valid), 32'd0);
    check("ready_after_resp", 32'(query_ready), rel ? 32'd0 : 32'd1);
    check("hold_resp_hp", 32'(resp_hp), 32'(exp.hp));
  endtask

  initial begin
    resp_t r;
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t r;
`ifdef BRICK_HP_EN
    tbl[0] = '{addr: 6'd5,  hit: 1'b1, exp: '{alive: 1'b1, hp: 2'd1, destroyed: 1'b0, left: 7'd60}};
    tbl[1] = '{addr: 6'd5,  hit: 1'b1, exp: '{alive: 1'b1, hp: 2'd0, destroyed: 1'b1, left: 7'd59}};
    tbl[2] = '{addr: 6'd5,  hit: 1'b0, exp: '{alive: 1'b0, hp: 2'd0, destroyed: 1'b0, left: 7'd59}};
    tbl[3] = '{addr: 6'd63, hit: 1'b1, exp: '{alive: 1'b0, hp: 2'd0, destroyed: 1'b0, left: 7'd59}};
    tbl[4] = '{addr: 6'd60, hit: 1'b0, exp: '{alive: 1'b0, hp: 2'd0, destroyed: 1'b0, left: 7'd59}};
    tbl[5] = '{addr: 6'd0,  hit: 1'b0, exp: '{alive: 1'b1, hp: 2'd2, destroyed: 1'b0, left: 7'd59}};
    tbl[6] = '{addr: 6'd0,  hit: 1'b1, exp: '{alive: 1'b1, hp: 2'd1, destroyed: 1'b0, left: 7'd59}};
    tbl[7] = '{addr: 6'd59, hit: 1'b1, exp: '{alive: 1'b1, hp: 2'd1, destroyed: 1'b0, left: 7'd59}};
`else
    tbl[0] = '{addr: 6'd5,  hit: 1'b1, exp: '{alive: 1'b1, hp: 2'd0, destroyed: 1'b1, left: 7'd59}};
    tbl[1] = '{addr: 6'd5,  hit: 1'b1, exp: '{alive: 1'b0, hp: 2'd0, destroyed: 1'b0, left: 7'd59}};
    tbl[2] = '{addr: 6'd5,  hit: 1'b0, exp: '{alive: 1'b0, hp: 2'd0, destroyed: 1'b0, left: 7'd59}};
    tbl[3] = '{addr: 6'd63, hit: 1'b1, exp: '{alive: 1'b0, hp: 2'd0, destroyed: 1'b0, left: 7'd59}};
    tbl[4] = '{addr: 6'd60, hit: 1'b0, exp: '{alive: 1'b0, hp: 2'd0, destroyed: 1'b0, left: 7'd59}};
    tbl[5] = '{addr: 6'd0,  hit: 1'b0, exp: '{alive: 1'b1, hp: 2'd1, destroyed: 1'b0, left: 7'd59}};
    tbl[6] = '{addr: 6'd0,  hit: 1'b1, exp: '{alive: 1'b1, hp: 2'd0, destroyed: 1'b1, left: 7'd58}};
    tbl[7] = '{addr: 6'd59, hit: 1'b1, exp: '{alive: 1'b1, hp: 2'd0, destroyed: 1'b1, left: 7'd57}};
`endif

    resetn      = 1'b0;
    reload      = 1'b0;
    query_valid = 1'b0;
    query_addr  = '0;
    query_hit   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_loading", 32'(loading), 32'd1);
    check("rst_ready", 32'(query_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_fields", {29'd0, resp_alive, resp_hp}, 32'd0);
    check("rst_destroyed", 32'(resp_destroyed), 32'd0);
    check("rst_bricks_left", 32'(bricks_left), 32'd0);
    check("rst_all_cleared", 32'(all_cleared), 32'd0);

    resetn = 1'b1;
    wait_ready("init_cycles");
    check("init_bricks_left", 32'(bricks_left), 32'(NB));
    check("init_all_cleared", 32'(all_cleared), 32'd0);
    model_reset();

    for (int i = 0; i < 8; i++) begin
      r = model_step(int'(tbl[i].addr), tbl[i].hit);
      send(tbl[i].addr, tbl[i].hit, tbl[i].exp, 1'b0);
    end

    // Knock every brick down to zero.
    for (int a = 0; a < NB; a++) begin
      while (model_hp[a] > 0) begin
        r = model_step(a, 1'b1);
        send(AW'(a), 1'b1, r, 1'b0);
      end
    end
    check("cleared_flag", 32'(all_cleared), 32'd1);
    check("cleared_left", 32'(bricks_left), 32'd0);
    r = model_step(10, 1'b1);
    send(6'd10, 1'b1, r, 1'b0);
    check("no_underflow", 32'(bricks_left), 32'd0);

    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    check("reload_loading", 32'(loading), 32'd1);
    check("reload_cleared_low", 32'(all_cleared), 32'd0);
    wait_ready("reload_init_cycles");
    check("reload_left", 32'(bricks_left), 32'(NB));
    model_reset();

    // Query and reload together: query wins, reload runs after RESP.
    r = model_step(1, 1'b0);
    send(6'd1, 1'b0, r, 1'b1);
    check("late_reload_loading", 32'(loading), 32'd1);
    wait_ready("late_reload_init_cycles");
    model_reset();

    // Reset one cycle after acceptance must drop the query.
    query_valid = 1'b1;
    query_addr  = 6'd3;
    query_hit   = 1'b1;
    @(negedge clock);
    query_valid = 1'b0;
    resetn      = 1'b0;
    #1;
    check("midq_rst_loading", 32'(loading), 32'd1);
    check("midq_rst_ready", 32'(query_ready), 32'd0);
    check("midq_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    wait_ready("midq_init_cycles");
    check("midq_left", 32'(bricks_left), 32'(NB));
    model_reset();
    r = model_step(3, 1'b1);
    send(6'd3, 1'b1, r, 1'b0);

    repeat (4) @(negedge clock);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
